zx_bus_front: RTL
=================

// Module: zx_bus_front
// PURPOSE
//  Clocked front end between the raw Z80 edge-connector bus and the cartridge paging logic.
//  - Synchronises and glitch-filters the asynchronous control strobes.
//  - Tracks each bus cycle with a small FSM.
//  - Emits clean single-cycle events: page_up_stb drives the ROM page counter; lower_rom_rd is the qualified lower-8K read.
//  - Flags stuck or illegal bus cycles.
// PARAMETERS
//  SYNC_STAGES  2    flip-flop synchroniser depth on every bus input (>=2)
//  FILT_LEN     3    consecutive equal synchronised samples needed to change a filtered strobe (>=1)
//  TIMEOUT_CYC  255  max clocks a cycle may stay active before HUNG (>=FILT_LEN+2)
//  CNT_W        8    width of io_evt_cnt
// PORTS
//  clk           in   1      system clock
//  reset_n       in   1      synchronous reset, active low
//  iorq_n        in   1      Z80 IORQ, async
//  mreq_n        in   1      Z80 MREQ, async
//  rd_n          in   1      Z80 RD, async
//  wr_n          in   1      Z80 WR, async
//  m1_n          in   1      Z80 M1, async (IORQ+M1 = interrupt acknowledge)
//  A7,A13,A14,A15 in  1 each address bits, async
//  page_up_stb   out  1      1-clk pulse: I/O cycle with A7=0, not INTA
//  lower_rom_rd  out  1      level: memory read with A15..A13=000 in progress
//  io_evt_cnt    out  CNT_W  count of page_up_stb pulses, wraps
//  bus_err       out  1      sticky: timeout or IORQ&MREQ both active
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - outputs 0, io_evt_cnt=0, FSM=IDLE
//   - filtered strobes=1, synchronisers=1, filter counters=0, armed=0
//  Sync: all inputs pass SYNC_STAGES flops. Address bits are not filtered.
//  Filter: per strobe (iorq,mreq,rd), a counter counts synced samples differing from the filtered value.
//   - Counter clears on any agreeing sample.
//   - Filtered value flips when count reaches FILT_LEN.
//   - A pulse shorter than FILT_LEN clks is ignored.
//  armed: set once filtered iorq=1 AND mreq=1 are seen after reset. FSM leaves IDLE only when armed=1.
//   A strobe held low through reset therefore never produces an event.
//  FSM states: IDLE, IO_CYC, MEM_CYC, HUNG.
//   IDLE->IO_CYC when filtered iorq=0. Latches A7 and m1 (synced values) at entry. IO has priority over MEM.
//   IDLE->MEM_CYC when filtered mreq=0 and iorq=1.
//   IO_CYC: in the first clk after entry, page_up_stb=1 iff latched A7=0 and latched m1_n=1; io_evt_cnt+1 in the same clk.
//   IO_CYC->IDLE when filtered iorq=1.
//   MEM_CYC: lower_rom_rd = filtered rd=0 AND synced A15,A14,A13=000, registered, re-evaluated every clk.
//   MEM_CYC->IDLE when filtered mreq=1; lower_rom_rd drops in the same clk.
//   Any active state: if filtered iorq=0 AND mreq=0 at the same time, set bus_err.
//   Any active state: a watchdog counts clks in state; reaching TIMEOUT_CYC -> HUNG, bus_err=1, outputs 0.
//   HUNG->IDLE only when filtered iorq=1 AND mreq=1.
//  Latency: raw iorq_n fall to page_up_stb = SYNC_STAGES+FILT_LEN+1 clks (6 at defaults). Deterministic.
//  At most one page_up_stb per IO_CYC, however long the cycle lasts.
//  io_evt_cnt wraps 2^CNT_W-1 -> 0.
//  bus_err clears only on reset.
//  Reset mid-cycle: abort immediately. No pulse is emitted.
// STRUCTURE
//  Package zx_cart_pkg:
//   - FSM state enum (2 bits)
//   - localparams for the lower-ROM address decode (A15..A13 = 3'b000) and the page-up decode (A7 = 0)
//   These are shared with zx_cartrige.
//  Sub-module zx_sync_filter: SYNC_STAGES synchroniser + FILT_LEN filter for one bit; instantiated for iorq, mreq, rd.
//  Top holds armed, FSM, watchdog, counters.
// TESTING
//  1 Reset, hold iorq_n=1, mreq_n=1 for 10 clks, then iorq_n=0 with A7=0, m1_n=1 -> page_up_stb exactly 1 clk, 6 clks after fall; io_evt_cnt=1.
//  2 iorq_n low with A7=1, then a separate cycle with m1_n=0,A7=0 -> no page_up_stb; io_evt_cnt stays 0.
//  3 2-clk iorq_n glitch (FILT_LEN=3) -> no strobe, FSM stays IDLE; 3-clk pulse -> one strobe.
//  4 mreq_n=rd_n=0, A15..A13=000 -> lower_rom_rd=1; set A13=1 -> 0 after SYNC_STAGES+1 clks; release mreq_n -> 0.
//  5 iorq_n held low through reset release -> no strobe until iorq_n rises and falls again; hold low 300 clks -> bus_err=1 at clk 255 in state, sticky.
//  6 256 valid I/O cycles -> io_evt_cnt wraps to 0; reset asserted mid IO_CYC -> no pulse, all outputs 0 the next clk.

Source files
------------

// File: rtl/zx_cart_pkg.sv
// zx_cart_pkg: shared bus-cycle state encoding and address decodes for the cartridge paging logic
package zx_cart_pkg;
  typedef enum logic [1:0] {IDLE, IO_CYC, MEM_CYC, HUNG} bus_state_t;
  localparam logic [2:0] LOWER_ROM_A = 3'b000;
  localparam logic PAGE_UP_A7 = 1'b0;
endpackage

// File: rtl/zx_sync_filter.sv
// zx_sync_filter: multi-flop synchroniser followed by a run-length glitch filter for one active-low strobe
module zx_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  // shift the raw input through the synchroniser; flip q only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '1;
      cnt <= '0;
      q <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      if (sync[SYNC_STAGES-1] == q) cnt <= '0;
      else if (cnt == CW'(FILT_LEN - 1)) begin
        q <= sync[SYNC_STAGES-1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/zx_bus_front.sv
// zx_bus_front: synchronises the Z80 bus, tracks bus cycles and emits clean paging events
module zx_bus_front
  import zx_cart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic iorq_n,
  input  logic mreq_n,
  input  logic rd_n,
  input  logic wr_n,
  input  logic m1_n,
  input  logic A7,
  input  logic A13,
  input  logic A14,
  input  logic A15,
  output logic page_up_stb,
  output logic lower_rom_rd,
  output logic [CNT_W-1:0] io_evt_cnt,
  output logic bus_err
);
  localparam int SETTLE = SYNC_STAGES + FILT_LEN;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  bus_state_t state;
  logic iorq_f, mreq_f, rd_f;
  logic [SYNC_STAGES-1:0][4:0] asy;
  logic [SW-1:0] settle;
  logic [WW-1:0] wd;
  logic armed, settled, m1_s, a7_s, lower_hit;
  logic [2:0] a_hi;
  zx_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_iorq (.clk(clk), .reset_n(reset_n), .d(iorq_n), .q(iorq_f));
  zx_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_mreq (.clk(clk), .reset_n(reset_n), .d(mreq_n), .q(mreq_f));
  zx_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_rd (.clk(clk), .reset_n(reset_n), .d(rd_n), .q(rd_f));
  // write strobes are not decoded by this front end
  logic unused_wr;
  assign unused_wr = wr_n;
  assign {m1_s, a_hi, a7_s} = asy[SYNC_STAGES-1];
  assign settled = settle == SW'(SETTLE);
  assign lower_hit = !rd_f && a_hi == LOWER_ROM_A;
  // unfiltered synchroniser for M1 and the decoded address bits
  always_ff @(posedge clk) begin
    if (!reset_n) asy <= '1;
    else asy <= {asy[SYNC_STAGES-2:0], {m1_n, A15, A14, A13, A7}};
  end
  // arming waits until the reset-loaded pipeline has flushed, so a strobe held low through reset is never taken as a new cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      settle <= '0;
      armed <= 1'b0;
    end else begin
      if (!settled) settle <= settle + 1'b1;
      if (settled && iorq_f && mreq_f) armed <= 1'b1;
    end
  end
  // bus-cycle FSM with watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      wd <= '0;
      page_up_stb <= 1'b0;
      lower_rom_rd <= 1'b0;
      io_evt_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      page_up_stb <= 1'b0;
      case (state)
        IDLE: begin
          wd <= '0;
          lower_rom_rd <= 1'b0;
          if (armed && !iorq_f) begin
            state <= IO_CYC;
            page_up_stb <= a7_s == PAGE_UP_A7 && m1_s;
            if (a7_s == PAGE_UP_A7 && m1_s) io_evt_cnt <= io_evt_cnt + 1'b1;
          end else if (armed && !mreq_f) begin
            state <= MEM_CYC;
            lower_rom_rd <= lower_hit;
          end
        end
        IO_CYC, MEM_CYC: begin
          wd <= wd + 1'b1;
          if (!iorq_f && !mreq_f) bus_err <= 1'b1;
          lower_rom_rd <= state == MEM_CYC && lower_hit;
          if (wd == WW'(TIMEOUT_CYC - 1)) begin
            state <= HUNG;
            bus_err <= 1'b1;
            lower_rom_rd <= 1'b0;
          end else if (state == IO_CYC ? iorq_f : mreq_f) begin
            state <= IDLE;
            lower_rom_rd <= 1'b0;
          end
        end
        default: if (iorq_f && mreq_f) state <= IDLE;
      endcase
    end
  end
endmodule
